// File: rtl/mau_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
//   - Memory access size encodings
//   - FSM state type for the sub-word read-modify-write sequence
//   - is_misaligned(): alignment/legality rule for a request
package mau_pkg;

  localparam logic [1:0] MAU_SIZE_WORD = 2'b00;
  localparam logic [1:0] MAU_SIZE_HALF = 2'b01;
  localparam logic [1:0] MAU_SIZE_BYTE = 2'b10;
  localparam logic [1:0] MAU_SIZE_ILL  = 2'b11;

  typedef enum logic {
    MAU_IDLE   = 1'b0,
    MAU_RMW_WR = 1'b1
  } mau_state_t;

  // Illegal size, odd half address, or non-word-aligned word address.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      MAU_SIZE_WORD: bad = (addr_lo != 2'b00);
      MAU_SIZE_HALF: bad = addr_lo[0];
      MAU_SIZE_BYTE: bad = 1'b0;
      default:       bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mau_lane_mux.sv
// Combinational byte-lane datapath.
//   i_size      access size (mau_pkg encodings)
//   i_unsigned  1 = zero-extend loads, 0 = sign-extend
//   i_addr_lo   Address[1:0], little-endian lane select
//   i_rdata     word read from data memory
//   i_wdata     store data, sub-word value in the low bits
//   o_load_data extracted and extended load value
//   o_merged    i_rdata with the addressed lane(s) replaced by i_wdata
module mau_lane_mux
  import mau_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merged
);

  logic [4:0]  w_shamt;
  logic [31:0] w_shifted;
  logic [31:0] w_mask;

  assign w_shamt   = {i_addr_lo, 3'b000};
  assign w_shifted = i_rdata >> w_shamt;

  always_comb begin
    o_load_data = i_rdata;
    w_mask      = 32'hFFFF_FFFF;
    case (i_size)
      MAU_SIZE_BYTE: begin
        o_load_data = {{24{~i_unsigned & w_shifted[7]}}, w_shifted[7:0]};
        w_mask      = 32'h0000_00FF << w_shamt;
      end
      MAU_SIZE_HALF: begin
        o_load_data = {{16{~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
        w_mask      = 32'h0000_FFFF << w_shamt;
      end
      default: begin
        o_load_data = i_rdata;
        w_mask      = 32'hFFFF_FFFF;
      end
    endcase
  end

  assign o_merged = (i_rdata & ~w_mask) | ((i_wdata << w_shamt) & w_mask);

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store front end for a word-only data memory.
// Loads are extracted/extended combinationally; word stores go straight
// through; byte/half stores use a two-cycle read-modify-write with a
// one-cycle stall. Misaligned/illegal requests are flagged and never write.
// Ports:
//   clk, reset (async, active-high)
//   MemRead, MemWrite, MemSize, MemUnsigned, Address, WriteData  - request
//   LoadData, Stall, MisalignErr                                 - to pipeline
//   DM_Address, DM_WriteData, DM_MemWrite, DM_MemRead, DM_ReadData - data memory
//   MisalignCount - only when MAU_MISALIGN_CNT_EN is defined; saturating
//                   count of cycles with MisalignErr=1
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        MemSize,
  input  logic              MemUnsigned,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       WriteData,
  output logic [31:0]       LoadData,
  output logic              Stall,
  output logic              MisalignErr,
  output logic [ADDR_W-1:0] DM_Address,
  output logic [31:0]       DM_WriteData,
  output logic              DM_MemWrite,
  output logic              DM_MemRead,
  input  logic [31:0]       DM_ReadData
`ifdef MAU_MISALIGN_CNT_EN
  ,
  output logic [CNT_W-1:0]  MisalignCount
`endif
);

  mau_state_t        r_state;
  logic [31:0]       r_merge_buf;
  logic [ADDR_W-1:0] r_addr_buf;

  logic        w_err;
  logic        w_rmw_start;
  logic [31:0] w_load_ext;
  logic [31:0] w_merged;

  assign w_err       = (MemRead | MemWrite) & is_misaligned(MemSize, Address[1:0]);
  assign w_rmw_start = (r_state == MAU_IDLE) & MemWrite & ~w_err & (MemSize != MAU_SIZE_WORD);

  mau_lane_mux u_lane_mux (
    .i_size      (MemSize),
    .i_unsigned  (MemUnsigned),
    .i_addr_lo   (Address[1:0]),
    .i_rdata     (DM_ReadData),
    .i_wdata     (WriteData),
    .o_load_data (w_load_ext),
    .o_merged    (w_merged)
  );

  // Outputs are gated by reset so an in-flight RMW write is cut off at once.
  always_comb begin
    LoadData     = 32'd0;
    Stall        = 1'b0;
    MisalignErr  = 1'b0;
    DM_Address   = '0;
    DM_WriteData = 32'd0;
    DM_MemWrite  = 1'b0;
    DM_MemRead   = 1'b0;
    if (!reset) begin
      if (r_state == MAU_RMW_WR) begin
        DM_Address   = {r_addr_buf[ADDR_W-1:2], 2'b00};
        DM_WriteData = r_merge_buf;
        DM_MemWrite  = 1'b1;
      end else begin
        DM_Address = {Address[ADDR_W-1:2], 2'b00};
        if (w_err) begin
          MisalignErr = 1'b1;
        end else if (MemWrite) begin
          if (MemSize == MAU_SIZE_WORD) begin
            DM_MemWrite  = 1'b1;
            DM_WriteData = WriteData;
          end else begin
            DM_MemRead = 1'b1;
            Stall      = 1'b1;
          end
        end else if (MemRead) begin
          DM_MemRead = 1'b1;
          LoadData   = w_load_ext;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= MAU_IDLE;
      r_merge_buf <= 32'd0;
      r_addr_buf  <= '0;
    end else begin
      case (r_state)
        MAU_IDLE: begin
          if (w_rmw_start) begin
            r_merge_buf <= w_merged;
            r_addr_buf  <= Address;
            r_state     <= MAU_RMW_WR;
          end
        end
        default: r_state <= MAU_IDLE;
      endcase
    end
  end

`ifdef MAU_MISALIGN_CNT_EN
  logic [CNT_W-1:0] r_misalign_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_misalign_cnt <= '0;
    end else if (MisalignErr && (r_misalign_cnt != {CNT_W{1'b1}})) begin
      r_misalign_cnt <= r_misalign_cnt + CNT_W'(1);
    end
  end

  assign MisalignCount = r_misalign_cnt;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam int TB_CNT_W = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite, MemUnsigned;
  logic [1:0]  MemSize;
  logic [31:0] Address, WriteData;
  logic [31:0] LoadData, DM_Address, DM_WriteData, DM_ReadData;
  logic        Stall, MisalignErr, DM_MemWrite, DM_MemRead;
`ifdef MAU_MISALIGN_CNT_EN
  logic [TB_CNT_W-1:0] MisalignCount;
  int exp_cnt = 0;
`endif

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32), .CNT_W(TB_CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .MemSize      (MemSize),
    .MemUnsigned  (MemUnsigned),
    .Address      (Address),
    .WriteData    (WriteData),
    .LoadData     (LoadData),
    .Stall        (Stall),
    .MisalignErr  (MisalignErr),
    .DM_Address   (DM_Address),
    .DM_WriteData (DM_WriteData),
    .DM_MemWrite  (DM_MemWrite),
    .DM_MemRead   (DM_MemRead),
    .DM_ReadData  (DM_ReadData)
`ifdef MAU_MISALIGN_CNT_EN
    ,
    .MisalignCount(MisalignCount)
`endif
  );

  // Data memory: combinational read, write on negedge.
  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];
  assign DM_ReadData = mem[DM_Address[7:2]];
  always @(negedge clk) if (DM_MemWrite) mem[DM_Address[7:2]] <= DM_WriteData;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    MemRead = 0; MemWrite = 0; MemSize = 2'b00; MemUnsigned = 0;
    Address = 0; WriteData = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size, input logic uns);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = ref_mem[addr[7:2]];
    b = w[8*addr[1:0] +: 8];
    h = w[16*addr[1] +: 16];
    case (size)
      2'b10:   return uns ? 32'(b) : 32'($signed(b));
      2'b01:   return uns ? 32'(h) : 32'($signed(h));
      default: return w;
    endcase
  endfunction

  task automatic ref_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data);
    case (size)
      2'b10:   ref_mem[addr[7:2]][8*addr[1:0] +: 8] = data[7:0];
      2'b01:   ref_mem[addr[7:2]][16*addr[1] +: 16] = data[15:0];
      default: ref_mem[addr[7:2]] = data;
    endcase
  endtask

  task automatic mem_intact(input string tag);
    logic same;
    same = 1'b1;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) same = 1'b0;
    check(tag, 32'(same), 32'd1);
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [1:0] size, input logic uns);
    MemRead = 1; MemSize = size; MemUnsigned = uns; Address = addr;
    #1;
    $display("load  addr=%h size=%0d uns=%0d data=%h", addr, size, uns, LoadData);
    check("load_data", LoadData, ref_load(addr, size, uns));
    check("load_stall", 32'(Stall), 32'd0);
    check("load_dmread", 32'(DM_MemRead), 32'd1);
    next_cycle();
    idle();
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data);
    MemWrite = 1; MemSize = size; Address = addr; WriteData = data;
    #1;
    $display("store addr=%h size=%0d data=%h", addr, size, data);
    if (size == 2'b00) begin
      check("sw_stall", 32'(Stall), 32'd0);
      check("sw_dmwrite", 32'(DM_MemWrite), 32'd1);
      next_cycle();
    end else begin
      check("rmw1_stall", 32'(Stall), 32'd1);
      check("rmw1_dmwrite", 32'(DM_MemWrite), 32'd0);
      next_cycle();
      check("rmw2_stall", 32'(Stall), 32'd0);
      check("rmw2_dmwrite", 32'(DM_MemWrite), 32'd1);
      check("rmw2_addr", DM_Address, {addr[31:2], 2'b00});
      next_cycle();
    end
    idle();
    ref_store(addr, size, data);
    check("store_mem", mem[addr[7:2]], ref_mem[addr[7:2]]);
  endtask

  task automatic do_bad(input logic [31:0] addr, input logic [1:0] size, input logic wr);
    MemRead = ~wr; MemWrite = wr; MemSize = size; Address = addr; WriteData = 32'hA5A5_5A5A;
    #1;
    $display("bad   addr=%h size=%0d wr=%0d err=%0d", addr, size, wr, MisalignErr);
    check("bad_err", 32'(MisalignErr), 32'd1);
    check("bad_stall", 32'(Stall), 32'd0);
    check("bad_dmwrite", 32'(DM_MemWrite), 32'd0);
    check("bad_load", LoadData, 32'd0);
    next_cycle();
    idle();
    mem_intact("bad_mem");
`ifdef MAU_MISALIGN_CNT_EN
    if (exp_cnt < (1 << TB_CNT_W) - 1) exp_cnt++;
    check("bad_cnt", 32'(MisalignCount), 32'(exp_cnt));
`endif
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'(i) * 32'h0101_0101;
    mem[1] = 32'h80FF_7F01;
    mem[2] = 32'h1122_3344;
    for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];

    // Reset holds every output at zero even with an active request.
    reset = 1;
    idle();
    MemRead = 1; MemWrite = 1; Address = 32'h0000_0014; WriteData = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    $display("reset outputs ld=%h st=%0d wr=%0d rd=%0d", LoadData, Stall, DM_MemWrite, DM_MemRead);
    check("rst_load", LoadData, 32'd0);
    check("rst_dmwrite", 32'(DM_MemWrite), 32'd0);
    check("rst_dmread", 32'(DM_MemRead), 32'd0);
    check("rst_stall", 32'(Stall), 32'd0);
    check("rst_addr", DM_Address, 32'd0);
    idle();
    next_cycle();
    reset = 0;
    #1;
    check("idle_dmread", 32'(DM_MemRead), 32'd0);
    check("idle_load", LoadData, 32'd0);
`ifdef MAU_MISALIGN_CNT_EN
    check("rst_cnt", 32'(MisalignCount), 32'd0);
`endif
    next_cycle();

    // Byte/half loads from 0x80FF7F01 at 0x04.
    do_load(32'h05, 2'b10, 1'b0);
    do_load(32'h07, 2'b10, 1'b0);
    do_load(32'h07, 2'b10, 1'b1);
    do_load(32'h06, 2'b01, 1'b0);

    // Sub-word RMW store, word store, then half RMW over it.
    do_store(32'h09, 2'b10, 32'h0000_00AA);
    check("sb_const", mem[2], 32'h1122_AA44);
    do_store(32'h10, 2'b00, 32'hDEAD_BEEF);
    check("sw_const", mem[4], 32'hDEAD_BEEF);
    do_store(32'h12, 2'b01, 32'h0000_1234);
    check("sh_const", mem[4], 32'h1234_BEEF);

    // Misaligned / illegal requests.
    do_bad(32'h0A, 2'b00, 1'b1);
    do_bad(32'h03, 2'b01, 1'b1);
    do_bad(32'h00, 2'b11, 1'b0);
    do_bad(32'h21, 2'b01, 1'b0);
    do_bad(32'h1E, 2'b00, 1'b0);

    // Simultaneous read and write: store wins, no load data.
    MemRead = 1; MemWrite = 1; MemSize = 2'b00; Address = 32'h14; WriteData = 32'hCAFE_F00D;
    #1;
    $display("rw    addr=%h ld=%h wr=%0d", Address, LoadData, DM_MemWrite);
    check("rw_load", LoadData, 32'd0);
    check("rw_dmwrite", 32'(DM_MemWrite), 32'd1);
    next_cycle();
    idle();
    ref_store(32'h14, 2'b00, 32'hCAFE_F00D);
    check("rw_mem", mem[5], 32'hCAFE_F00D);

    // Back-to-back sub-word stores.
    do_store(32'h20, 2'b10, 32'h0000_0055);
    do_store(32'h22, 2'b01, 32'h0000_BEAD);
    do_store(32'h21, 2'b10, 32'h0000_0066);

    // Reset arriving during RMW_WR, before the negedge write.
    MemWrite = 1; MemSize = 2'b10; Address = 32'h0C; WriteData = 32'h0000_0099;
    next_cycle();
    check("abort_pre_dmwrite", 32'(DM_MemWrite), 32'd1);
    reset = 1;
    #1;
    $display("abort addr=%h wr=%0d stall=%0d", DM_Address, DM_MemWrite, Stall);
    check("abort_dmwrite", 32'(DM_MemWrite), 32'd0);
    check("abort_stall", 32'(Stall), 32'd0);
    idle();
    @(posedge clk); #1;
    reset = 0;
    #1;
    mem_intact("abort_mem");
    check("abort_idle_stall", 32'(Stall), 32'd0);
`ifdef MAU_MISALIGN_CNT_EN
    exp_cnt = 0;
    check("abort_cnt", 32'(MisalignCount), 32'd0);
`endif
    next_cycle();
    do_store(32'h0C, 2'b10, 32'h0000_0099);

    // Randomized mix against the reference model.
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      int op;
      op = int'($urandom_range(0, 2));
      sz = 2'($urandom_range(0, 2));
      a  = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      if (op == 2) begin
        case (2'($urandom_range(0, 2)))
          2'd0:    begin sz = 2'b11; a[1:0] = 2'($urandom_range(0, 3)); end
          2'd1:    begin sz = 2'b01; a[1:0] = {1'($urandom_range(0, 1)), 1'b1}; end
          default: begin sz = 2'b00; a[1:0] = 2'($urandom_range(1, 3)); end
        endcase
        do_bad(a, sz, 1'($urandom_range(0, 1)));
      end else begin
        if (sz == 2'b10) a[1:0] = 2'($urandom_range(0, 3));
        if (sz == 2'b01) a[1]   = 1'($urandom_range(0, 1));
        if (op == 0) do_load(a, sz, 1'($urandom_range(0, 1)));
        else         do_store(a, sz, $urandom);
      end
    end
    mem_intact("final_mem");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
